// File: rtl/trx_sequencer_pkg.sv
// Shared types and constants for the TX/RX frame sequencer.
package trx_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTxFetch,
        StTxLoad,
        StTxWait,
        StRxWait,
        StDone
    } trx_state_e;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_TX   = 2'b01;
    localparam logic [1:0] SEL_RX   = 2'b10;

    localparam int unsigned CHIPS_PER_SYMBOL         = 32;
    localparam int unsigned DEFAULT_UNDERRUN_TIMEOUT = 64;

    function automatic logic [1:0] sel_of(trx_state_e st);
        logic [1:0] sel;
        case (st)
            StTxFetch, StTxLoad, StTxWait: sel = SEL_TX;
            StRxWait:                      sel = SEL_RX;
            default:                       sel = SEL_IDLE;
        endcase
        return sel;
    endfunction

    function automatic logic [6:0] sat_inc(logic [6:0] v);
        return (v == 7'd127) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/trx_wait_timer.sv
// Clearable saturating up-counter; clear wins over enable.
module trx_wait_timer #(
    parameter int unsigned Width    = 7,
    parameter int unsigned MaxCount = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != Width'(MaxCount))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/trx_sequencer.sv
// Frame sequencer: feeds the chip coder from the input FIFO (TX) or drains the
// decoder into the output FIFO (RX), with abort, underrun and overflow handling.
module trx_sequencer
    import trx_sequencer_pkg::*;
#(
    parameter int unsigned UNDERRUN_TIMEOUT = DEFAULT_UNDERRUN_TIMEOUT
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic       inMode,
    input  logic [6:0] inFrameLen,
    input  logic       inAbort,
    input  logic       inFifoEmpty,
    output logic       outFifoReadEnable,
    output logic       outCoderLoad,
    input  logic       inCoderDone,
    input  logic       inDecoderValid,
    input  logic [3:0] inDecoderData,
    input  logic       inOutFifoFull,
    output logic       outOutFifoWriteEnable,
    output logic [3:0] outOutFifoData,
    output logic [1:0] outSel,
    output logic       outBusy,
    output logic       outDone,
    output logic [6:0] outSymbolCount,
    output logic       outUnderrun,
    output logic       outOverflow,
    output logic       outLenError
);

    localparam int unsigned TimerWidth = $clog2(UNDERRUN_TIMEOUT + 1);

    trx_state_e       state_q, state_d;
    logic [6:0]       len_q, len_d;
    logic [6:0]       cnt_q, cnt_d;
    logic             und_q, und_d;
    logic             ovf_q, ovf_d;
    logic             lerr_q, lerr_d;
    logic             wr_en_q, wr_en_d;
    logic [3:0]       wr_data_q, wr_data_d;
    logic [1:0]       sel_q;
    logic             busy_q, load_q, done_q;
    logic [6:0]       cnt_inc;
    logic             timer_en;
    logic             timer_expired;
    logic [TimerWidth-1:0] wait_count;

    assign timer_en      = (state_q == StTxFetch) && inFifoEmpty;
    assign timer_expired = timer_en && (wait_count == TimerWidth'(UNDERRUN_TIMEOUT - 1));
    assign cnt_inc       = sat_inc(cnt_q);

    trx_wait_timer #(
        .Width    (TimerWidth),
        .MaxCount (UNDERRUN_TIMEOUT)
    ) u_wait_timer (
        .clk_i   (inClock),
        .rst_i   (inReset),
        .clr_i   (!timer_en),
        .en_i    (timer_en),
        .count_o (wait_count)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        und_d     = und_q;
        ovf_d     = ovf_q;
        lerr_d    = lerr_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        if (inAbort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (inStart) begin
                        if (inFrameLen == 7'd0) begin
                            lerr_d = 1'b1;
                        end else begin
                            len_d   = inFrameLen;
                            cnt_d   = 7'd0;
                            und_d   = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = inMode ? StRxWait : StTxFetch;
                        end
                    end
                end
                StTxFetch: begin
                    if (!inFifoEmpty) begin
                        state_d = StTxLoad;
                    end else if (timer_expired) begin
                        und_d   = 1'b1;
                        state_d = StDone;
                    end
                end
                StTxLoad: state_d = StTxWait;
                StTxWait: begin
                    if (inCoderDone) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == len_q) ? StDone : StTxFetch;
                    end
                end
                StRxWait: begin
                    if (inDecoderValid) begin
                        cnt_d = cnt_inc;
                        if (inOutFifoFull) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = inDecoderData;
                        end
                        if (cnt_inc == len_q) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Decoded outputs are registered from the next state so they change with state_q.
    // The RX write strobe lags its capture by one cycle, so it may land in DONE/IDLE.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state_q   <= StIdle;
            len_q     <= 7'd0;
            cnt_q     <= 7'd0;
            und_q     <= 1'b0;
            ovf_q     <= 1'b0;
            lerr_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 4'd0;
            sel_q     <= SEL_IDLE;
            busy_q    <= 1'b0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            und_q     <= und_d;
            ovf_q     <= ovf_d;
            lerr_q    <= lerr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            sel_q     <= sel_of(state_d);
            busy_q    <= (state_d != StIdle);
            load_q    <= (state_d == StTxLoad);
            done_q    <= (state_d == StDone);
        end
    end

    assign outFifoReadEnable     = (state_q == StTxFetch) && !inFifoEmpty;
    assign outCoderLoad          = load_q;
    assign outOutFifoWriteEnable = wr_en_q;
    assign outOutFifoData        = wr_data_q;
    assign outSel                = sel_q;
    assign outBusy               = busy_q;
    assign outDone               = done_q;
    assign outSymbolCount        = cnt_q;
    assign outUnderrun           = und_q;
    assign outOverflow           = ovf_q;
    assign outLenError           = lerr_q;

endmodule

// File: tb/tb_trx_sequencer.sv
// Directed bench for trx_sequencer: TX, underrun, RX overflow, length error, abort, reset.
module tb_trx_sequencer;
    import trx_sequencer_pkg::*;

    logic       inClock = 1'b0;
    logic       inReset;
    logic       inStart;
    logic       inMode;
    logic [6:0] inFrameLen;
    logic       inAbort;
    logic       inFifoEmpty;
    logic       outFifoReadEnable;
    logic       outCoderLoad;
    logic       inCoderDone;
    logic       inDecoderValid;
    logic [3:0] inDecoderData;
    logic       inOutFifoFull;
    logic       outOutFifoWriteEnable;
    logic [3:0] outOutFifoData;
    logic [1:0] outSel;
    logic       outBusy;
    logic       outDone;
    logic [6:0] outSymbolCount;
    logic       outUnderrun;
    logic       outOverflow;
    logic       outLenError;

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int ld_cnt   = 0;
    int done_cnt = 0;
    logic [3:0] wr_log[$];

    trx_sequencer #(
        .UNDERRUN_TIMEOUT (64)
    ) dut (
        .inClock               (inClock),
        .inReset               (inReset),
        .inStart               (inStart),
        .inMode                (inMode),
        .inFrameLen            (inFrameLen),
        .inAbort               (inAbort),
        .inFifoEmpty           (inFifoEmpty),
        .outFifoReadEnable     (outFifoReadEnable),
        .outCoderLoad          (outCoderLoad),
        .inCoderDone           (inCoderDone),
        .inDecoderValid        (inDecoderValid),
        .inDecoderData         (inDecoderData),
        .inOutFifoFull         (inOutFifoFull),
        .outOutFifoWriteEnable (outOutFifoWriteEnable),
        .outOutFifoData        (outOutFifoData),
        .outSel                (outSel),
        .outBusy               (outBusy),
        .outDone               (outDone),
        .outSymbolCount        (outSymbolCount),
        .outUnderrun           (outUnderrun),
        .outOverflow           (outOverflow),
        .outLenError           (outLenError)
    );

    always #5 inClock = ~inClock;

    always @(posedge inClock) begin
        if (outFifoReadEnable) rd_cnt <= rd_cnt + 1;
        if (outCoderLoad) ld_cnt <= ld_cnt + 1;
        if (outDone) done_cnt <= done_cnt + 1;
        if (outOutFifoWriteEnable) wr_log.push_back(outOutFifoData);
    end

    task automatic tick();
        @(posedge inClock);
        #1;
    endtask

    task automatic wait_load(output bit ok);
        int n = 0;
        while (outCoderLoad !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = (outCoderLoad === 1'b1);
    endtask

    task automatic test_reset();
        inReset = 1'b1; inStart = 1'b0; inMode = 1'b0; inFrameLen = 7'd0; inAbort = 1'b0;
        inFifoEmpty = 1'b1; inCoderDone = 1'b0; inDecoderValid = 1'b0; inDecoderData = 4'd0;
        inOutFifoFull = 1'b0;
        repeat (2) tick();
        checks++;
        if ({outFifoReadEnable, outCoderLoad, outOutFifoWriteEnable, outOutFifoData, outSel,
             outBusy, outDone, outSymbolCount, outUnderrun, outOverflow, outLenError} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b sel=%b cnt=%0d required all zero",
                     outBusy, outSel, outSymbolCount);
        end
        inReset = 1'b0;
        tick();
        checks++;
        if (outBusy !== 1'b0 || outSel !== SEL_IDLE) begin
            failures++;
            $display("FAIL reset_idle: busy=%b sel=%b required 0/00", outBusy, outSel);
        end
    endtask

    task automatic test_tx();
        int rd0 = rd_cnt;
        int ld0 = ld_cnt;
        int dn0 = done_cnt;
        bit ok;
        inFifoEmpty = 1'b0; inMode = 1'b0; inFrameLen = 7'd3; inStart = 1'b1;
        tick();
        inStart = 1'b0;
        checks++;
        if (outSel !== SEL_TX || outBusy !== 1'b1) begin
            failures++;
            $display("FAIL tx_enter: sel=%b busy=%b required 01/1", outSel, outBusy);
        end
        for (int s = 0; s < 3; s++) begin
            wait_load(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL tx_load%0d: outCoderLoad=%b required 1", s, outCoderLoad);
            end
            // a stray start while busy must be ignored
            inStart = (s == 1); inFrameLen = 7'd1;
            tick();
            inStart = 1'b0;
            repeat (CHIPS_PER_SYMBOL - 1) tick();
            inCoderDone = 1'b1;
            tick();
            inCoderDone = 1'b0;
        end
        checks++;
        if (outDone !== 1'b1 || outSymbolCount !== 7'd3) begin
            failures++;
            $display("FAIL tx_done: done=%b cnt=%0d required 1/3", outDone, outSymbolCount);
        end
        tick();
        checks++;
        if (rd_cnt - rd0 != 3 || ld_cnt - ld0 != 3 || done_cnt - dn0 != 1) begin
            failures++;
            $display("FAIL tx_strobes: reads=%0d loads=%0d dones=%0d required 3/3/1",
                     rd_cnt - rd0, ld_cnt - ld0, done_cnt - dn0);
        end
        checks++;
        if (outBusy !== 1'b0 || outSel !== SEL_IDLE || outDone !== 1'b0) begin
            failures++;
            $display("FAIL tx_idle: busy=%b sel=%b done=%b required 0/00/0",
                     outBusy, outSel, outDone);
        end
    endtask

    task automatic test_underrun();
        int n = 0;
        bit ok;
        inFifoEmpty = 1'b0; inMode = 1'b0; inFrameLen = 7'd2; inStart = 1'b1;
        tick();
        inStart = 1'b0;
        wait_load(ok);
        inFifoEmpty = 1'b1;
        repeat (CHIPS_PER_SYMBOL) tick();
        inCoderDone = 1'b1;
        tick();
        inCoderDone = 1'b0;
        while (outDone !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 64) begin
            failures++;
            $display("FAIL underrun_latency: cycles=%0d required 64", n);
        end
        checks++;
        if (outDone !== 1'b1 || outUnderrun !== 1'b1 || outSymbolCount !== 7'd1) begin
            failures++;
            $display("FAIL underrun_flags: done=%b underrun=%b cnt=%0d required 1/1/1",
                     outDone, outUnderrun, outSymbolCount);
        end
        tick();
        checks++;
        if (outSel !== SEL_IDLE || outBusy !== 1'b0 || outUnderrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_idle: sel=%b busy=%b underrun=%b required 00/0/1",
                     outSel, outBusy, outUnderrun);
        end
        inFifoEmpty = 1'b0;
    endtask

    task automatic test_rx();
        logic [3:0] sym [4];
        logic       full[4];
        int         w0 = wr_log.size();
        sym[0] = 4'hA; sym[1] = 4'hE; sym[2] = 4'h2; sym[3] = 4'h9;
        full[0] = 1'b0; full[1] = 1'b0; full[2] = 1'b1; full[3] = 1'b0;
        inMode = 1'b1; inFrameLen = 7'd4; inStart = 1'b1;
        tick();
        inStart = 1'b0;
        checks++;
        if (outSel !== SEL_RX || outUnderrun !== 1'b0) begin
            failures++;
            $display("FAIL rx_enter: sel=%b underrun=%b required 10/0", outSel, outUnderrun);
        end
        for (int s = 0; s < 4; s++) begin
            inDecoderValid = 1'b1; inDecoderData = sym[s]; inOutFifoFull = full[s];
            tick();
            inDecoderValid = 1'b0; inOutFifoFull = 1'b0;
            if (s < 3) tick();
        end
        checks++;
        if (outDone !== 1'b1 || outSymbolCount !== 7'd4 || outOverflow !== 1'b1) begin
            failures++;
            $display("FAIL rx_done: done=%b cnt=%0d overflow=%b required 1/4/1",
                     outDone, outSymbolCount, outOverflow);
        end
        repeat (2) tick();
        checks++;
        if (wr_log.size() - w0 != 3) begin
            failures++;
            $display("FAIL rx_write_count: writes=%0d required 3", wr_log.size() - w0);
        end else begin
            checks++;
            if (wr_log[w0] !== 4'hA || wr_log[w0+1] !== 4'hE || wr_log[w0+2] !== 4'h9) begin
                failures++;
                $display("FAIL rx_write_data: got %h %h %h required a e 9",
                         wr_log[w0], wr_log[w0+1], wr_log[w0+2]);
            end
        end
    endtask

    task automatic test_len_error();
        int rd0 = rd_cnt;
        int ld0 = ld_cnt;
        int dn0 = done_cnt;
        int w0  = wr_log.size();
        inMode = 1'b0; inFrameLen = 7'd0; inStart = 1'b1;
        tick();
        inStart = 1'b0;
        checks++;
        if (outLenError !== 1'b1 || outBusy !== 1'b0) begin
            failures++;
            $display("FAIL len_error: lenerr=%b busy=%b required 1/0", outLenError, outBusy);
        end
        repeat (3) tick();
        checks++;
        if (rd_cnt != rd0 || ld_cnt != ld0 || done_cnt != dn0 || wr_log.size() != w0
            || outBusy !== 1'b0) begin
            failures++;
            $display("FAIL len_error_quiet: reads=%0d loads=%0d dones=%0d busy=%b required 0/0/0/0",
                     rd_cnt - rd0, ld_cnt - ld0, done_cnt - dn0, outBusy);
        end
    endtask

    task automatic test_abort();
        int  dn0;
        bit  ok;
        inFifoEmpty = 1'b0; inMode = 1'b0; inFrameLen = 7'd5; inStart = 1'b1;
        tick();
        inStart = 1'b0;
        wait_load(ok);
        repeat (CHIPS_PER_SYMBOL) tick();
        inCoderDone = 1'b1;
        tick();
        inCoderDone = 1'b0;
        wait_load(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_second_load: outCoderLoad=%b required 1", outCoderLoad);
        end
        tick();
        dn0 = done_cnt;
        inAbort = 1'b1;
        tick();
        inAbort = 1'b0;
        checks++;
        if (outBusy !== 1'b0 || outSel !== SEL_IDLE || outSymbolCount !== 7'd1
            || outDone !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b sel=%b cnt=%0d done=%b required 0/00/1/0",
                     outBusy, outSel, outSymbolCount, outDone);
        end
        tick();
        checks++;
        if (done_cnt != dn0) begin
            failures++;
            $display("FAIL abort_no_done: dones=%0d required 0", done_cnt - dn0);
        end
        inMode = 1'b1; inFrameLen = 7'd1; inStart = 1'b1;
        tick();
        inStart = 1'b0;
        checks++;
        if (outBusy !== 1'b1 || outSel !== SEL_RX || outSymbolCount !== 7'd0) begin
            failures++;
            $display("FAIL abort_restart: busy=%b sel=%b cnt=%0d required 1/10/0",
                     outBusy, outSel, outSymbolCount);
        end
        inDecoderValid = 1'b1; inDecoderData = 4'h5;
        tick();
        inDecoderValid = 1'b0;
        checks++;
        if (outDone !== 1'b1 || outSymbolCount !== 7'd1) begin
            failures++;
            $display("FAIL abort_restart_done: done=%b cnt=%0d required 1/1",
                     outDone, outSymbolCount);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_frame();
        int dn0;
        int w0;
        inMode = 1'b1; inFrameLen = 7'd4; inStart = 1'b1;
        tick();
        inStart = 1'b0;
        inDecoderValid = 1'b1; inDecoderData = 4'h3; inOutFifoFull = 1'b0;
        tick();
        inDecoderValid = 1'b0;
        dn0 = done_cnt;
        w0  = wr_log.size();
        #2 inReset = 1'b1;
        #1;
        checks++;
        if ({outOutFifoWriteEnable, outOutFifoData, outSel, outBusy, outDone, outSymbolCount,
             outUnderrun, outOverflow, outLenError, outFifoReadEnable, outCoderLoad} !== '0) begin
            failures++;
            $display("FAIL reset_async: wr=%b busy=%b sel=%b cnt=%0d lenerr=%b required all zero",
                     outOutFifoWriteEnable, outBusy, outSel, outSymbolCount, outLenError);
        end
        tick();
        inReset = 1'b0;
        repeat (3) tick();
        checks++;
        if (done_cnt != dn0 || wr_log.size() != w0 || outBusy !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: dones=%0d writes=%0d busy=%b required 0/0/0",
                     done_cnt - dn0, wr_log.size() - w0, outBusy);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_underrun();
        test_rx();
        test_len_error();
        test_abort();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
